// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that hands bytes from N_REQ requesters to a single uart_tx.
// A watchdog flags (sticky) a uart_tx that never raises busy after a start.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         i_req_valid,
  input  logic [8*N_REQ-1:0]       i_req_data,
  output logic [N_REQ-1:0]         o_req_ready,
  output logic                     o_tx_start,
  output logic [7:0]               o_tx_data,
  input  logic                     i_tx_busy,
  input  logic                     i_tx_done,
  output logic [$clog2(N_REQ)-1:0] o_grant_id,
  output logic                     o_active,
  output logic                     o_err_timeout
);
  localparam int unsigned IdW  = $clog2(N_REQ);
  localparam int unsigned CntW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StStart, StWaitDone} state_e;

  state_e          r_state, w_state_d;
  logic [IdW-1:0]  r_rr_ptr, r_grant_id, w_pick_id, w_id, w_next_ptr;
  logic [N_REQ-1:0] w_pick_oh;
  logic            w_found, w_xfer, w_timeout, w_to_idle;
  logic [CntW-1:0] r_cnt;
  logic [7:0]      r_tx_data;
  logic            r_tx_start, r_err;
  int              w_idx;

  // Search upward from the round-robin pointer, wrapping to 0.
  always_comb begin
    w_pick_oh = '0;
    w_pick_id = '0;
    w_found   = 1'b0;
    w_idx     = 0;
    w_id      = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= int'(N_REQ)) w_idx = w_idx - int'(N_REQ);
      w_id = IdW'(w_idx);
      if (!w_found && i_req_valid[w_id]) begin
        w_found          = 1'b1;
        w_pick_oh[w_id]  = 1'b1;
        w_pick_id        = w_id;
      end
    end
  end

  assign w_xfer     = (r_state == StIdle) && w_found && !reset;
  assign w_timeout  = (r_cnt == CntW'(BUSY_TIMEOUT - 1));
  assign w_next_ptr = (r_grant_id == IdW'(N_REQ - 1)) ? '0 : r_grant_id + 1'b1;
  assign w_to_idle  = (r_state != StIdle) && (w_state_d == StIdle);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: if (w_xfer) w_state_d = StStart;
      StStart: begin
        if (i_tx_done)      w_state_d = StIdle;
        else if (i_tx_busy) w_state_d = StWaitDone;
        else if (w_timeout) w_state_d = StIdle;
      end
      StWaitDone: if (i_tx_done || !i_tx_busy) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    o_req_ready = w_xfer ? w_pick_oh : '0;
    o_active    = (r_state != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_tx_start <= (w_state_d == StStart);
      // Counts START cycles; cleared whenever START is not the current state.
      r_cnt      <= (r_state == StStart) ? r_cnt + 1'b1 : '0;
      if (w_xfer) begin
        r_tx_data  <= i_req_data[{w_pick_id, 3'b000} +: 8];
        r_grant_id <= w_pick_id;
      end
      if (w_to_idle) r_rr_ptr <= w_next_ptr;
      if ((r_state == StStart) && !i_tx_done && !i_tx_busy && w_timeout) r_err <= 1'b1;
    end
  end

  assign o_tx_start    = r_tx_start;
  assign o_tx_data     = r_tx_data;
  assign o_grant_id    = r_grant_id;
  assign o_err_timeout = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed + randomized bench for uart_tx_arbiter against a round-robin reference model,
// finishing with a serial uart_tx model and line decoder for back-to-back frames.
module tb_uart_tx_arbiter;
  localparam int N        = 4;
  localparam int TO       = 16;
  localparam int BAUD_DIV = 10;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tb_busy, tb_done, uart_en;
  logic           tx_busy, tx_done;
  logic [1:0]     grant_id;
  logic           active, err_timeout;

  int   n_vec = 0;
  int   n_err = 0;
  int   m_rr;
  logic m_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .BUSY_TIMEOUT(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_req_valid  (req_valid),
    .i_req_data   (req_data),
    .o_req_ready  (req_ready),
    .o_tx_start   (tx_start),
    .o_tx_data    (tx_data),
    .i_tx_busy    (tx_busy),
    .i_tx_done    (tx_done),
    .o_grant_id   (grant_id),
    .o_active     (active),
    .o_err_timeout(err_timeout)
  );

  // Behavioural uart_tx: 10-bit frame at BAUD_DIV clocks per bit, done pulse at the end.
  logic       u_busy = 1'b0;
  logic       u_done = 1'b0;
  logic [9:0] u_shift = '1;
  int         u_cnt = 0;
  int         u_bit = 0;
  logic       tx_line;

  assign tx_busy = uart_en ? u_busy : tb_busy;
  assign tx_done = uart_en ? u_done : tb_done;
  assign tx_line = u_busy ? u_shift[0] : 1'b1;

  always @(posedge clk) begin
    u_done <= 1'b0;
    if (uart_en) begin
      if (!u_busy) begin
        if (tx_start) begin
          u_shift <= {1'b1, tx_data, 1'b0};
          u_busy  <= 1'b1;
          u_cnt   <= 0;
          u_bit   <= 0;
        end
      end else if (u_cnt == BAUD_DIV - 1) begin
        u_cnt   <= 0;
        u_shift <= {1'b1, u_shift[9:1]};
        u_bit   <= u_bit + 1;
        if (u_bit == 9) begin
          u_busy <= 1'b0;
          u_done <= 1'b1;
        end
      end else begin
        u_cnt <= u_cnt + 1;
      end
    end
  end

  // Independent line decoder: samples mid-bit, checks start/stop levels.
  logic       rx_prev = 1'b1;
  logic       rx_on = 1'b0;
  logic       rx_bad = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh = '0;
  logic [7:0] rx_q[$];

  always @(posedge clk) begin
    rx_prev <= tx_line;
    if (rx_on) begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt == 5 && tx_line !== 1'b0) rx_bad <= 1'b1;
      if (rx_cnt > 5 && rx_cnt < 90 && rx_cnt % 10 == 5) rx_sh <= {tx_line, rx_sh[7:1]};
      if (rx_cnt == 95) begin
        if (tx_line !== 1'b1) rx_bad <= 1'b1;
        rx_q.push_back(rx_sh);
        rx_on <= 1'b0;
      end
    end else if (uart_en && rx_prev && !tx_line) begin
      rx_on  <= 1'b1;
      rx_cnt <= 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration rule: first valid index at or above rr, wrapping.
  function automatic int pick(input int rr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  // mode 0: done in START; 1: busy then done/drop; 2: never accepted; 3: busy+done together
  task automatic frame(input logic [N-1:0] v, input logic [8*N-1:0] d, input int mode,
                       input int dly, input int blen);
    int p;
    logic [7:0] b;
    req_valid = v;
    req_data  = d;
    #1;
    p = pick(m_rr, v);
    chk("ready_onehot", {28'd0, req_ready}, (p < 0) ? 32'd0 : (32'd1 << p));
    if (p < 0) begin
      tick();
      chk("noreq_active", {31'd0, active}, 32'd0);
      chk("noreq_start", {31'd0, tx_start}, 32'd0);
      return;
    end
    b = d[8*p +: 8];
    tick();
    req_valid = N'($urandom);
    req_data  = $urandom;
    chk("start_hi", {31'd0, tx_start}, 32'd1);
    chk("tx_data", {24'd0, tx_data}, {24'd0, b});
    chk("grant_id", {30'd0, grant_id}, p);
    chk("active_hi", {31'd0, active}, 32'd1);
    chk("ready_quiet", {28'd0, req_ready}, 32'd0);
    case (mode)
      0: begin
        repeat (dly) begin chk("start_hold", {31'd0, tx_start}, 32'd1); tick(); end
        tb_done = 1'b1; tick(); tb_done = 1'b0;
      end
      1: begin
        repeat (dly) begin chk("start_hold", {31'd0, tx_start}, 32'd1); tick(); end
        tb_busy = 1'b1; tick();
        chk("wait_start_lo", {31'd0, tx_start}, 32'd0);
        repeat (blen) tick();
        chk("wait_active", {31'd0, active}, 32'd1);
        chk("wait_data", {24'd0, tx_data}, {24'd0, b});
        if (dly % 2 == 1) begin
          tb_done = 1'b1; tick(); tb_done = 1'b0; tb_busy = 1'b0;
        end else begin
          tb_busy = 1'b0; tick();
        end
      end
      2: begin
        for (int i = 0; i < TO; i++) begin
          chk("to_start_hi", {31'd0, tx_start}, 32'd1);
          tick();
        end
        m_err = 1'b1;
      end
      default: begin
        tb_busy = 1'b1; tb_done = 1'b1; tick(); tb_busy = 1'b0; tb_done = 1'b0;
      end
    endcase
    m_rr = (p + 1) % N;
    chk("end_active", {31'd0, active}, 32'd0);
    chk("end_start", {31'd0, tx_start}, 32'd0);
    chk("err_timeout", {31'd0, err_timeout}, {31'd0, m_err});
    chk("data_stable", {24'd0, tx_data}, {24'd0, b});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0]   acc, pend;
    logic [8*N-1:0] ud;
    logic [7:0]     exp_q[$];
    int             p, rr, cyc;

    tb_busy = 1'b0; tb_done = 1'b0; uart_en = 1'b0;
    req_data = '0; req_valid = '1; reset = 1'b1;
    m_rr = 0; m_err = 1'b0;
    #2;
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_start", {31'd0, tx_start}, 32'd0);
    chk("rst_active", {31'd0, active}, 32'd0);
    chk("rst_err", {31'd0, err_timeout}, 32'd0);
    chk("rst_data", {24'd0, tx_data}, 32'd0);
    chk("rst_grant", {30'd0, grant_id}, 32'd0);
    req_valid = '0;
    #10 reset = 1'b0;
    tick();

    // Single request
    frame(4'b0001, 32'h0000_0041, 0, 2, 0);
    // Round-robin with all requesters held valid
    for (int i = 0; i < 5; i++) frame(4'b1111, 32'h4332_2110, 1, i, 2);
    // Wrap from the top requester back to 0
    frame(4'b0100, 32'h0000_0000, 0, 0, 0);
    frame(4'b1001, 32'hC3_0000_B0, 0, 1, 0);
    frame(4'b1001, 32'hC3_0000_B0, 3, 0, 0);
    // Watchdog, then arbitration continues
    frame(4'b0001, 32'h0000_0077, 2, 0, 0);
    frame(4'b0010, 32'h0000_8800, 0, 0, 0);

    for (int i = 0; i < 40; i++)
      frame(N'($urandom), $urandom, int'($urandom_range(0, 3)),
            int'($urandom_range(0, 5)), int'($urandom_range(0, 4)));

    // Reset while waiting for done with busy high
    req_valid = 4'b0001;
    tick();
    tb_busy = 1'b1; req_valid = '0;
    tick();
    chk("pre_rst_active", {31'd0, active}, 32'd1);
    req_valid = 4'b1111;
    reset = 1'b1;
    #1;
    chk("midrst_start", {31'd0, tx_start}, 32'd0);
    chk("midrst_active", {31'd0, active}, 32'd0);
    chk("midrst_err", {31'd0, err_timeout}, 32'd0);
    chk("midrst_ready", {28'd0, req_ready}, 32'd0);
    req_valid = '0;
    #2;
    reset = 1'b0; tb_busy = 1'b0; m_rr = 0; m_err = 1'b0;
    tick();
    frame(4'b0010, 32'h0000_6600, 1, 1, 1);

    // Back-to-back frames through the serial model
    uart_en = 1'b1;
    ud = 32'h000F_AA55;
    req_data = ud; req_valid = 4'b0111;
    pend = 4'b0111; rr = m_rr;
    for (int i = 0; i < 3; i++) begin
      p = pick(rr, pend);
      exp_q.push_back(ud[8*p +: 8]);
      pend[p] = 1'b0;
      rr = (p + 1) % N;
    end
    cyc = 0;
    while (rx_q.size() < 3 && cyc < 2000) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~acc;
      cyc++;
    end
    m_rr = rr;
    chk("uart_frames", rx_q.size(), 32'd3);
    for (int i = 0; i < 3; i++)
      chk("uart_byte", (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hFFFF_FFFF, {24'd0, exp_q[i]});
    chk("uart_framing", {31'd0, rx_bad}, 32'd0);
    repeat (20) tick();
    chk("uart_idle", {31'd0, active}, 32'd0);
    uart_en = 1'b0;
    frame(4'b1000, 32'h5A00_0000, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of byte requesters sharing one uart_tx (range 2..8).
REQ-002 SHALL have parameter BUSY_TIMEOUT, default 16, clk cycles allowed for uart_tx to raise busy after tx_start.
REQ-003 Port clk  in  1  system clock; all logic on posedge.
REQ-004 Port reset  in  1  reset, asynchronous, active-high.
REQ-005 Port req_valid  in  N_REQ  per-requester byte-available flag.
REQ-006 Port req_data  in  8*N_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-007 Port req_ready  out  N_REQ  one-hot accept strobe.
REQ-008 Port tx_start  out  1  start request to uart_tx.
REQ-009 Port tx_data  out  8  byte to uart_tx data_in.
REQ-010 Port tx_busy  in  1  uart_tx busy.
REQ-011 Port tx_done  in  1  uart_tx single-cycle frame-complete pulse.
REQ-012 Port grant_id  out  $clog2(N_REQ)  index of current/last granted requester.
REQ-013 Port active  out  1  high whenever state != IDLE.
REQ-014 Port err_timeout  out  1  sticky flag: uart_tx failed to accept a start.

Function
REQ-015 SHALL implement FSM states IDLE, START, WAIT_DONE.
REQ-016 IDLE: req_ready SHALL be combinational, one-hot at the first set req_valid bit searching from rr_ptr upward with wrap to 0; all zero if no req_valid.
REQ-017 Transfer SHALL occur on the edge where req_valid[i] & req_ready[i]; on that edge tx_data <= req_data[i], grant_id <= i, state <= START.
REQ-018 req_ready SHALL be zero in START and WAIT_DONE; at most one bit high in any cycle.
REQ-019 tx_start SHALL be registered: high in every START cycle, low in all others; first high cycle is the cycle after the transfer edge.
REQ-020 START: tx_done=1 SHALL go to IDLE (frame completed); else tx_busy=1 SHALL go to WAIT_DONE; tx_done takes precedence over tx_busy.
REQ-021 START: a cycle counter SHALL clear on entry; if BUSY_TIMEOUT cycles elapse with tx_busy=0 and tx_done=0, SHALL set err_timeout and go to IDLE.
REQ-022 WAIT_DONE: tx_done=1 or tx_busy=0 SHALL go to IDLE.
REQ-023 On every exit to IDLE (done or timeout), rr_ptr SHALL be set to grant_id+1, wrapping N_REQ-1 -> 0.
REQ-024 tx_data SHALL remain stable from the transfer edge until the next transfer edge.
REQ-025 At least one IDLE cycle SHALL separate consecutive frames; grant in that IDLE cycle is permitted.
REQ-026 A req_valid deasserted before acceptance SHALL drop that request with no side effects.
REQ-027 req_valid changes outside IDLE SHALL not affect the current frame.
REQ-028 err_timeout SHALL remain set until reset; it SHALL not block further arbitration.
REQ-029 active SHALL equal (state != IDLE), registered state, no combinational path from inputs.

Reset
REQ-030 reset=1 SHALL immediately force state=IDLE, tx_start=0, tx_data=0, grant_id=0, rr_ptr=0, err_timeout=0, timeout counter=0, active=0.
REQ-031 reset mid-frame SHALL abandon the frame; after release the arbiter SHALL accept a new request with rr_ptr=0.
REQ-032 req_ready SHALL be all zero while reset=1.

Verification
REQ-033 Single request: req_valid=0001, req_data[7:0]=0x41 -> req_ready=0001 same cycle, tx_start high next cycle, tx_data=0x41, grant_id=0, IDLE after tx_done.
REQ-034 Round-robin: req_valid=1111 held, data 0x10/0x21/0x32/0x43 -> grant order 0,1,2,3,0; tx_data sequence 0x10,0x21,0x32,0x43,0x10.
REQ-035 Wrap: rr_ptr=3 with req_valid=1001 -> grant 3 then 0; rr_ptr=0 after 3 completes.
REQ-036 Timeout: tx_busy tied 0, tx_done 0, one request -> tx_start high exactly 16 cycles, err_timeout=1, state IDLE, next request still granted.
REQ-037 Reset in WAIT_DONE with tx_busy=1 -> tx_start=0, active=0, err_timeout=0 same cycle; post-release request 0010 granted normally.
REQ-038 Back-to-back with real uart_tx/baud_gen (BAUD_DIV=10): three queued bytes 0x55,0xAA,0x0F -> three complete serial frames on tx in grant order, none corrupted.
